// File: rtl/mole_if.sv
// mole_if: run/keys from the game side and the mole screen/draw handshake toward drawImage.
interface mole_if;
  logic       run;
  logic [3:0] keys;
  logic       draw_done;
  logic [2:0] mole_state;
  logic       draw_req;
  logic       hit;
  logic       miss;
  logic [7:0] hit_count;
  modport master (output run, keys, draw_done, input mole_state, draw_req, hit, miss, hit_count);
  modport slave (input run, keys, draw_done, output mole_state, draw_req, hit, miss, hit_count);
endinterface

// File: rtl/mole_scheduler.sv
// mole_scheduler: gap, pseudo-random mole pick, redraw, timed hit window, redraw back.
// Define WHACK_SPEEDUP_EN to shrink the hit window on every hit.
module mole_scheduler #(
  parameter int unsigned UP_CYCLES  = 25_000_000,
  parameter int unsigned GAP_CYCLES = 12_500_000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input logic   clk,
  input logic   resetn,
  mole_if.slave bus
);
  localparam int unsigned MAX_CYC = UP_CYCLES > GAP_CYCLES ? UP_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam logic [2:0] GAME = 3'b001;
  typedef enum logic [2:0] {IDLE, GAP, DRAW_UP, UP, DRAW_DOWN} state_t;
  state_t        state_q, state_d;
  logic [3:0]    sync1_q, sync2_q, kprev_q, key_edge, sel_mask;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [CW-1:0] cnt_q, cnt_d, up_lim;
  logic [1:0]    sel_q, sel_d, pick;
  logic [2:0]    mole_q, mole_d;
  logic          draw_req_q, draw_req_d, hit_q, hit_d, miss_q, miss_d, wrong_key;
  logic [7:0]    hit_count_q, hit_count_d;
  assign key_edge  = sync2_q & ~kprev_q;
  assign sel_mask  = 4'b0001 << sel_q;
  assign wrong_key = |(key_edge & ~sel_mask);
  assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  // bump to the next mole rather than showing the same one twice in a row
  assign pick      = (lfsr_q[1:0] == sel_q) ? lfsr_q[1:0] + 2'd1 : lfsr_q[1:0];
`ifdef WHACK_SPEEDUP_EN
  localparam logic [CW-1:0] STEP  = CW'(UP_CYCLES >> 4);
  localparam logic [CW-1:0] FLOOR = CW'(UP_CYCLES >> 2);
  logic [CW-1:0] up_lim_q, up_lim_d;
  assign up_lim = up_lim_q;
  always_comb up_lim_d = (state_q == IDLE) ? CW'(UP_CYCLES) :
                         hit_d ? ((up_lim_q < FLOOR + STEP) ? FLOOR : up_lim_q - STEP) : up_lim_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) up_lim_q <= CW'(UP_CYCLES);
    else up_lim_q <= up_lim_d;
`else
  assign up_lim = CW'(UP_CYCLES);
`endif
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    mole_d      = mole_q;
    draw_req_d  = draw_req_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    hit_count_d = hit_count_q;
    if (!bus.run) begin
      state_d    = IDLE;
      cnt_d      = '0;
      mole_d     = GAME;
      draw_req_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d     = GAP;
          cnt_d       = '0;
          hit_count_d = '0;
        end
        GAP: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(GAP_CYCLES - 1)) begin
            sel_d      = pick;
            mole_d     = 3'b010 + {1'b0, pick};
            draw_req_d = 1'b1;
            state_d    = DRAW_UP;
          end
        end
        DRAW_UP: if (bus.draw_done) begin
          draw_req_d = 1'b0;
          cnt_d      = '0;
          state_d    = UP;
        end
        UP: begin
          cnt_d       = cnt_q + CW'(1);
          miss_d      = wrong_key || (key_edge == '0 && cnt_q == up_lim - CW'(1));
          hit_d       = !wrong_key && key_edge != '0;
          hit_count_d = hit_count_q + {7'd0, hit_d && hit_count_q != 8'hFF};
          if (hit_d || miss_d) begin
            mole_d     = GAME;
            draw_req_d = 1'b1;
            state_d    = DRAW_DOWN;
          end
        end
        DRAW_DOWN: if (bus.draw_done) begin
          draw_req_d = 1'b0;
          cnt_d      = '0;
          state_d    = GAP;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q     <= IDLE;
      sync1_q     <= '0;
      sync2_q     <= '0;
      kprev_q     <= '0;
      lfsr_q      <= LFSR_SEED;
      cnt_q       <= '0;
      sel_q       <= '0;
      mole_q      <= GAME;
      draw_req_q  <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      hit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= bus.keys;
      sync2_q     <= sync1_q;
      kprev_q     <= sync2_q;
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      mole_q      <= mole_d;
      draw_req_q  <= draw_req_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      hit_count_q <= hit_count_d;
    end
  assign bus.mole_state = mole_q;
  assign bus.draw_req   = draw_req_q;
  assign bus.hit        = hit_q;
  assign bus.miss       = miss_q;
  assign bus.hit_count  = hit_count_q;
endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: vector table, hand corner sequences and random rounds against a round-level model.
module tb_mole_scheduler;
  localparam int UP = 64;
  localparam int GAPC = 16;
  localparam logic [2:0] GAME = 3'b001;
  typedef struct {
    logic [3:0] rel;
    int         p;
    bit         hit;
    int         lat;
  } vec_t;
  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;
  mole_if bus();
  mole_scheduler #(.UP_CYCLES(UP), .GAP_CYCLES(GAPC), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .resetn(resetn), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [15:0] lf_cur = 16'hACE1;
  logic [15:0] lf_prev = 16'hACE1;
  logic [1:0] m_sel = 2'd0;
  logic [2:0] last_ms = 3'b010;
  int m_hc = 0;
  int m_lim = UP;
  int next_gap = 17;
  vec_t tbl[8];

  always @(posedge clk) if (resetn) begin
    lf_prev <= lf_cur;
    lf_cur  <= {lf_cur[14:0], ^(lf_cur & 16'hB400)};
  end

  initial begin
    int dcnt;
    dcnt = 0;
    bus.draw_done = 1'b0;
    forever begin
      @(negedge clk);
      dcnt = bus.draw_req ? dcnt + 1 : 0;
      bus.draw_done = (dcnt == 5);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic mole_up(input logic [3:0] gap_keys);
    int t;
    int stray;
    logic [1:0] s;
    logic [2:0] exp_ms;
    t = 0;
    stray = 0;
    do begin
      @(negedge clk);
      t++;
      if (t == 3) bus.keys = gap_keys;
      if (t == 8) bus.keys = 4'd0;
      stray += int'(bus.hit | bus.miss);
    end while (bus.mole_state == GAME && t < 300);
    check("gap_len", t, next_gap);
    check("gap_quiet", stray, 0);
    s = (lf_prev[1:0] == m_sel) ? lf_prev[1:0] + 2'd1 : lf_prev[1:0];
    m_sel = s;
    exp_ms = 3'b010 + {1'b0, s};
    check("mole_state", bus.mole_state, exp_ms);
    check("no_repeat", bus.mole_state != last_ms, 1);
    check("draw_req_up", bus.draw_req, 1);
    last_ms = exp_ms;
  endtask

  task automatic window(input string nm, input logic [3:0] rel, input int p,
                        input bit fixed, input bit f_hit, input int f_lat);
    int t;
    logic [7:0] rr;
    logic [3:0] mask;
    bit e_hit;
    int e_lat;
    logic got_hit, got_miss;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (bus.draw_req && t < 50);
    check({nm, " draw_up_len"}, t, 5);
    rr = {rel, rel} << m_sel;
    mask = rr[7:4];
    if (rel != 0 && p + 2 <= m_lim - 1) begin
      e_lat = p + 3;
      e_hit = (mask == 4'(1 << m_sel));
    end else begin
      e_lat = m_lim;
      e_hit = 1'b0;
    end
    if (fixed) begin
      e_hit = f_hit;
      e_lat = (f_lat == 0) ? m_lim : f_lat;
    end
    t = 0;
    while (!(bus.hit || bus.miss) && t < 300) begin
      if (rel != 0 && t == p) bus.keys = mask;
      @(negedge clk);
      t++;
    end
    got_hit = bus.hit;
    got_miss = bus.miss;
    check({nm, " latency"}, t, e_lat);
    check({nm, " hit"}, got_hit, e_hit);
    check({nm, " miss"}, got_miss, !e_hit);
    if (e_hit) m_hc = (m_hc == 255) ? 255 : m_hc + 1;
`ifdef WHACK_SPEEDUP_EN
    if (e_hit) m_lim = (m_lim - UP / 16 < UP / 4) ? UP / 4 : m_lim - UP / 16;
`endif
    check({nm, " hit_count"}, bus.hit_count, m_hc);
    check({nm, " mole_down"}, bus.mole_state, GAME);
    check({nm, " draw_req_down"}, bus.draw_req, 1);
    bus.keys = 4'd0;
    @(negedge clk);
    check({nm, " one_pulse"}, bus.hit | bus.miss, 0);
    t = 1;
    while (bus.draw_req && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({nm, " draw_down_len"}, t, 5);
    next_gap = 16;
  endtask

  initial begin
    int stray;
    int a;
    int p;
    logic [3:0] rel;
    bus.run = 1'b0;
    bus.keys = 4'd0;
    tbl[0] = '{4'b0000, 0, 1'b0, 0};
    tbl[1] = '{4'b0001, 62, 1'b0, 0};
    tbl[2] = '{4'b0001, 61, 1'b1, 64};
    tbl[3] = '{4'b0001, 0, 1'b1, 3};
    tbl[4] = '{4'b0011, 5, 1'b0, 8};
    tbl[5] = '{4'b0010, 10, 1'b0, 13};
    tbl[6] = '{4'b1111, 2, 1'b0, 5};
    tbl[7] = '{4'b0001, 20, 1'b1, 23};
    #2 resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst mole_state", bus.mole_state, GAME);
    check("rst draw_req", bus.draw_req, 0);
    check("rst hit", bus.hit, 0);
    check("rst miss", bus.miss, 0);
    check("rst hit_count", bus.hit_count, 0);
    resetn = 1'b1;
    bus.run = 1'b1;
    next_gap = 17;
    // key presses during the first gap must be ignored
    mole_up(4'b1111);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) mole_up(4'd0);
      window($sformatf("vec%0d", i), tbl[i].rel, tbl[i].p, 1'b1, tbl[i].hit, tbl[i].lat);
    end
    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, 3);
      rel = (a == 0) ? 4'd0 : (a == 1) ? 4'd1 : (a == 2) ? 4'($urandom_range(1, 15))
                     : ((4'($urandom_range(1, 7)) << 1) | 4'd1);
      p = $urandom_range(0, m_lim + 4);
      mole_up(4'd0);
      window("rnd", rel, p, 1'b0, 1'b0, 0);
    end
    mole_up(4'd0);
    @(negedge clk);
    bus.run = 1'b0;
    @(negedge clk);
    check("abort draw_req", bus.draw_req, 0);
    check("abort mole_state", bus.mole_state, GAME);
    stray = int'(bus.hit | bus.miss);
    repeat (20) begin
      @(negedge clk);
      stray += int'(bus.hit | bus.miss);
    end
    check("abort quiet", stray, 0);
    check("abort hit_count held", bus.hit_count, m_hc);
    bus.run = 1'b1;
    m_hc = 0;
    m_lim = UP;
    @(negedge clk);
    check("rerun hit_count", bus.hit_count, 0);
    next_gap = 16;
    for (int i = 0; i < 300; i++) begin
      p = $urandom_range(0, m_lim - 3);
      mole_up(4'd0);
      window("sat", 4'd1, p, 1'b0, 1'b0, 0);
    end
    check("saturated hit_count", bus.hit_count, 255);
    mole_up(4'd0);
`ifdef WHACK_SPEEDUP_EN
    window("final_timeout", 4'd0, 0, 1'b1, 1'b0, UP / 4);
`else
    window("final_timeout", 4'd0, 0, 1'b1, 1'b0, UP);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
